// File: rtl/sym_packer_pkg.sv
// Shared types and sizing helpers for the symbol packer and its output FIFO.
package sym_packer_pkg;

   typedef enum logic {ACCUM, FLUSH_PEND} packer_state_e;

   function automatic int sym_bits(input int m);
      return $clog2(m);
   endfunction

   // Pointer carries one extra wrap bit so full and empty are distinguishable.
   function automatic int ptr_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; a write while full without a read is dropped
// and flagged on ovf_wr. Read side is valid/ready: pop on rd_rdy while non-empty.
module sync_fifo
   import sym_packer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_vld,
   input  logic [WIDTH-1:0]           wr_dat,
   input  logic                       rd_rdy,
   output logic [WIDTH-1:0]           head_dat,
   output logic                       empty,
   output logic                       full,
   output logic [ptr_bits(DEPTH)-1:0] level,
   output logic                       ovf_wr
);
   localparam int PW = ptr_bits(DEPTH);
   localparam int IW = PW - 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d, lvl_after_rd;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_rd, do_wr;

   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign level        = wr_ptr_q - rd_ptr_q;
   assign do_rd        = rd_rdy && !empty;
   assign do_wr        = wr_vld && (!full || do_rd);
   assign ovf_wr       = wr_vld && full && !do_rd;
   assign rd_ptr_d     = rd_ptr_q + PW'(do_rd);
   assign lvl_after_rd = level - PW'(do_rd);
   assign head_dat     = head_q;

   // Next head: the incoming word if the queue would otherwise be empty, else the stored entry.
   always_comb begin
      head_d = mem_q[rd_ptr_d[IW-1:0]];
      if (lvl_after_rd == '0) begin
         head_d = do_wr ? wr_dat : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[IW-1:0]] <= wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PW'(do_wr);
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/sym_packer.sv
// Packs K-bit symbols MSB-first into OUT_W-bit words, queued behind a valid/ready FIFO.
// Upstream is never stalled: writes into a full FIFO are dropped and latch o_ovf.
module sym_packer
   import sym_packer_pkg::*;
#(
   parameter int MODULATION_ORDER = 16,
   parameter int OUT_W            = 8,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_dv,
   input  logic [sym_bits(MODULATION_ORDER)-1:0] binary_code,
   input  logic                                 i_flush,
   output logic                                 o_dv,
   input  logic                                 i_rdy,
   output logic [OUT_W-1:0]                     o_word,
   output logic                                 o_ovf,
   output logic [ptr_bits(FIFO_DEPTH)-1:0]      o_level
);
   localparam int K  = sym_bits(MODULATION_ORDER);
   localparam int AW = OUT_W + K - 1;
   localparam int FW = $clog2(OUT_W + K) + 1;
   localparam logic [FW-1:0] K_F  = FW'(K);
   localparam logic [FW-1:0] OW_F = FW'(OUT_W);
   localparam logic [FW-1:0] SH0  = FW'(AW - K);

   if (OUT_W < K) begin : g_bad_width
      $error("sym_packer: OUT_W must be >= log2(MODULATION_ORDER)");
   end
   if (MODULATION_ORDER < 2 || (MODULATION_ORDER & (MODULATION_ORDER - 1)) != 0) begin : g_bad_m
      $error("sym_packer: MODULATION_ORDER must be a power of 2, >= 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sym_packer: FIFO_DEPTH must be a power of 2, >= 2");
   end

   logic [AW-1:0]  acc_q, acc_d, acc_app;
   logic [FW-1:0]  fill_q, fill_d, fill_app;
   packer_state_e  state_q, state_d;
   logic           ovf_q;
   logic           wr_vld, fifo_empty, fifo_full, fifo_ovf;
   logic [OUT_W-1:0] wr_dat;

   // Accumulator is kept left-aligned; bits below the fill level are always zero.
   always_comb begin
      acc_app  = acc_q | (AW'(binary_code) << (SH0 - fill_q));
      fill_app = fill_q + K_F;
      acc_d    = acc_q;
      fill_d   = fill_q;
      state_d  = state_q;
      wr_vld   = 1'b0;
      wr_dat   = acc_q[AW-1 -: OUT_W];
      if (state_q == FLUSH_PEND) begin
         wr_vld  = 1'b1;
         state_d = ACCUM;
         acc_d   = '0;
         fill_d  = '0;
         if (i_dv) begin
            acc_d  = AW'(binary_code) << SH0;
            fill_d = K_F;
            if (i_flush) state_d = FLUSH_PEND;
         end
      end else if (i_dv) begin
         if (fill_app >= OW_F) begin
            wr_vld = 1'b1;
            wr_dat = acc_app[AW-1 -: OUT_W];
            acc_d  = acc_app << OUT_W;
            fill_d = fill_app - OW_F;
            if (i_flush && fill_d != '0) state_d = FLUSH_PEND;
         end else if (i_flush) begin
            wr_vld = 1'b1;
            wr_dat = acc_app[AW-1 -: OUT_W];
            acc_d  = '0;
            fill_d = '0;
         end else begin
            acc_d  = acc_app;
            fill_d = fill_app;
         end
      end else if (i_flush && fill_q != '0) begin
         wr_vld = 1'b1;
         acc_d  = '0;
         fill_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         fill_q  <= '0;
         state_q <= ACCUM;
         ovf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         ovf_q   <= ovf_q | fifo_ovf;
      end
   end

   sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_vld   (wr_vld),
      .wr_dat   (wr_dat),
      .rd_rdy   (i_rdy),
      .head_dat (o_word),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .level    (o_level),
      .ovf_wr   (fifo_ovf)
   );

   assign o_dv  = !fifo_empty;
   assign o_ovf = ovf_q;

   a_ovf_only_when_full: assert property (@(posedge clk) disable iff (!rst_n) fifo_ovf |-> fifo_full);

endmodule
